// File: rtl/zap_hwseq_pkg.sv
// Shared types and constants for the Thumb halfword sequencer.
package zap_hwseq_pkg;

  localparam int HWORD_W = 16;

  // EMPTY: no word held; LO/HI: Thumb halfword still to issue;
  // ARM: full 32-bit instruction; ABT: fetch abort to report.
  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_LO    = 3'd1,
    ST_HI    = 3'd2,
    ST_ARM   = 3'd3,
    ST_ABT   = 3'd4
  } hwseq_state_e;

  // The abort takes precedence over the instruction set. A Thumb word
  // fetched for a branch target at pc[1]=1 only holds its upper halfword.
  function automatic hwseq_state_e accept_state(input logic abort,
                                                input logic thumb,
                                                input logic pc_bit1);
    if (abort)        return ST_ABT;
    else if (!thumb)  return ST_ARM;
    else if (pc_bit1) return ST_HI;
    else              return ST_LO;
  endfunction

endpackage

// File: rtl/zap_thumb_hword_sequencer.sv
// Splits I-cache fetch words into issued instructions. A Thumb word becomes
// up to two zero-extended halfwords. An ARM word is issued whole. An aborted
// fetch becomes a single abort marker.
// Optional feature: define ZAP_HWSEQ_PERF_CNT_EN to add the o_hw_count
// counter of issued Thumb halfwords.
module zap_thumb_hword_sequencer
  import zap_hwseq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clear,
  input  logic        i_stall,
  input  logic [31:0] i_word,
  input  logic        i_word_valid,
  input  logic [31:0] i_word_pc,
  input  logic        i_iabort,
  input  logic        i_cpsr_t,
  output logic        o_word_ready,
  output logic [31:0] o_instruction,
  output logic        o_instruction_valid,
  output logic [31:0] o_pc,
  output logic        o_iabort,
  output logic        o_thumb
`ifdef ZAP_HWSEQ_PERF_CNT_EN
  ,
  output logic [31:0] o_hw_count
`endif
);

  hwseq_state_e state_q;
  hwseq_state_e load_state;
  logic [31:0]  word_q;
  logic [31:0]  pc_q;
  logic         abort_q;
  logic         t_q;
  logic [31:0]  instr_q;
  logic         valid_q;
  logic [31:0]  pc_out_q;
  logic         iabort_q;
  logic         thumb_q;
  logic         accept;

  // A new word can enter when the buffer is empty, even under stall. It can
  // also enter when the buffer's last output is leaving this cycle.
  always_comb begin
    o_word_ready = !i_clear &&
                   ((state_q == ST_EMPTY) ||
                    (((state_q == ST_HI) || (state_q == ST_ARM) || (state_q == ST_ABT)) && !i_stall));
    accept       = i_word_valid && o_word_ready;
    load_state   = accept_state(i_iabort, i_cpsr_t, i_word_pc[1]);
  end

  // Buffer load, state sequencing and registered issue outputs. A flush
  // beats both stall and accept. A stall freezes everything except the
  // load of an empty buffer.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_EMPTY;
      word_q   <= '0;
      pc_q     <= '0;
      abort_q  <= 1'b0;
      t_q      <= 1'b0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      pc_out_q <= '0;
      iabort_q <= 1'b0;
      thumb_q  <= 1'b0;
    end else if (i_clear) begin
      state_q  <= ST_EMPTY;
      valid_q  <= 1'b0;
      iabort_q <= 1'b0;
    end else begin
      if (!i_stall) begin
        unique case (state_q)
          ST_LO: begin
            instr_q  <= {{(32-HWORD_W){1'b0}}, word_q[HWORD_W-1:0]};
            pc_out_q <= {pc_q[31:2], 2'b00};
            valid_q  <= 1'b1;
            iabort_q <= abort_q;
            thumb_q  <= 1'b1;
            state_q  <= ST_HI;
          end
          ST_HI: begin
            instr_q  <= {{(32-HWORD_W){1'b0}}, word_q[31:HWORD_W]};
            pc_out_q <= {pc_q[31:2], 2'b10};
            valid_q  <= 1'b1;
            iabort_q <= abort_q;
            thumb_q  <= 1'b1;
            state_q  <= accept ? load_state : ST_EMPTY;
          end
          ST_ARM: begin
            instr_q  <= word_q;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            iabort_q <= abort_q;
            thumb_q  <= 1'b0;
            state_q  <= accept ? load_state : ST_EMPTY;
          end
          ST_ABT: begin
            instr_q  <= '0;
            pc_out_q <= pc_q;
            valid_q  <= 1'b1;
            iabort_q <= abort_q;
            thumb_q  <= t_q;
            state_q  <= accept ? load_state : ST_EMPTY;
          end
          default: begin
            valid_q  <= 1'b0;
            iabort_q <= 1'b0;
            state_q  <= accept ? load_state : ST_EMPTY;
          end
        endcase
      end else if (accept) begin
        state_q <= load_state;
      end
      if (accept) begin
        word_q  <= i_word;
        pc_q    <= i_word_pc;
        abort_q <= i_iabort;
        t_q     <= i_cpsr_t;
      end
    end
  end

  assign o_instruction       = instr_q;
  assign o_instruction_valid = valid_q;
  assign o_pc                = pc_out_q;
  assign o_iabort            = iabort_q;
  assign o_thumb             = thumb_q;

`ifdef ZAP_HWSEQ_PERF_CNT_EN
  logic [31:0] hw_count_q;

  // Counts each Thumb halfword as it issues. Only reset clears the count; a
  // flush does not.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hw_count_q <= '0;
    end else if (!i_clear && !i_stall && ((state_q == ST_LO) || (state_q == ST_HI))) begin
      hw_count_q <= hw_count_q + 32'd1;
    end
  end

  assign o_hw_count = hw_count_q;
`endif

endmodule

// File: tb/tb_zap_thumb_hword_sequencer.sv
// Scoreboard bench for zap_thumb_hword_sequencer. The bench also covers
// ZAP_HWSEQ_PERF_CNT_EN when that macro is defined.
module tb_zap_thumb_hword_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_clear = 1'b0;
  logic        i_stall = 1'b0;
  logic [31:0] i_word = '0;
  logic        i_word_valid = 1'b0;
  logic [31:0] i_word_pc = '0;
  logic        i_iabort = 1'b0;
  logic        i_cpsr_t = 1'b0;
  logic        o_word_ready;
  logic [31:0] o_instruction;
  logic        o_instruction_valid;
  logic [31:0] o_pc;
  logic        o_iabort;
  logic        o_thumb;
`ifdef ZAP_HWSEQ_PERF_CNT_EN
  logic [31:0] o_hw_count;
`endif

  zap_thumb_hword_sequencer dut (
    .i_clk               (i_clk),
    .i_reset_n           (i_reset_n),
    .i_clear             (i_clear),
    .i_stall             (i_stall),
    .i_word              (i_word),
    .i_word_valid        (i_word_valid),
    .i_word_pc           (i_word_pc),
    .i_iabort            (i_iabort),
    .i_cpsr_t            (i_cpsr_t),
    .o_word_ready        (o_word_ready),
    .o_instruction       (o_instruction),
    .o_instruction_valid (o_instruction_valid),
    .o_pc                (o_pc),
    .o_iabort            (o_iabort),
    .o_thumb             (o_thumb)
`ifdef ZAP_HWSEQ_PERF_CNT_EN
    ,
    .o_hw_count          (o_hw_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        iabort;
    logic        thumb;
  } issue_t;

  typedef enum {CHK_NONE, CHK_ISSUE, CHK_IDLE, CHK_FROZEN, CHK_RESET} chk_e;

  issue_t      expQ[$];
  issue_t      lastExp = '0;
  logic        lastValid = 1'b0;
  chk_e        chk = CHK_NONE;
  int          compared = 0;
  int          mismatched = 0;
  int          expectedHw = 0;
  logic        acc;
  logic [66:0] actualOut;

  assign actualOut = {o_instruction_valid, o_instruction, o_pc, o_iabort, o_thumb};

  // Records one comparison and prints a FAIL line if the values differ.
  task automatic checkOutput(input string name, input logic [66:0] act, input logic [66:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  // Reference model: builds the list of issues an accepted word should
  // produce, using the architectural rules with plain address arithmetic.
  task automatic pushWord(input logic [31:0] w, input logic [31:0] pc, input logic ab, input logic t);
    issue_t it;
    logic [31:0] base;
    base = pc & ~32'd3;
    if (ab) begin
      it = '{instr: 32'd0, pc: pc, iabort: 1'b1, thumb: t};
      expQ.push_back(it);
    end else if (!t) begin
      it = '{instr: w, pc: pc, iabort: 1'b0, thumb: 1'b0};
      expQ.push_back(it);
    end else begin
      if (pc[1] == 1'b0) begin
        it = '{instr: w & 32'h0000_FFFF, pc: base, iabort: 1'b0, thumb: 1'b1};
        expQ.push_back(it);
      end
      it = '{instr: w >> 16, pc: base + 32'd2, iabort: 1'b0, thumb: 1'b1};
      expQ.push_back(it);
    end
  endtask

  // Scoreboard side of each edge: decide what this edge should have done.
  always @(posedge i_clk) begin
    if (!i_reset_n) begin
      expQ.delete();
      lastValid  = 1'b0;
      lastExp    = '0;
      expectedHw = 0;
      chk        = CHK_RESET;
    end else begin
      acc = i_word_valid && o_word_ready;
      if (i_clear) begin
        expQ.delete();
        lastValid = 1'b0;
        chk       = CHK_IDLE;
      end else if (!i_stall) begin
        if (expQ.size() > 0) begin
          lastExp   = expQ.pop_front();
          lastValid = 1'b1;
          chk       = CHK_ISSUE;
          if (lastExp.thumb && !lastExp.iabort) expectedHw++;
        end else begin
          lastValid = 1'b0;
          chk       = CHK_IDLE;
        end
      end else begin
        chk = CHK_FROZEN;
      end
      if (acc) pushWord(i_word, i_word_pc, i_iabort, i_cpsr_t);
    end
  end

  // Monitor: compares the registered outputs half a cycle after each edge.
  always @(negedge i_clk) begin
    case (chk)
      CHK_RESET: checkOutput("reset_state", actualOut, 67'd0);
      CHK_ISSUE: checkOutput("issue", actualOut, {1'b1, lastExp});
      CHK_IDLE:  checkOutput("idle_valid_abort", {65'd0, o_instruction_valid, o_iabort}, 67'd0);
      CHK_FROZEN: begin
        if (lastValid) checkOutput("stall_frozen", actualOut, {1'b1, lastExp});
        else           checkOutput("stall_idle", {65'd0, o_instruction_valid, o_iabort}, 67'd0);
      end
      default: ;
    endcase
  end

  // Offers one word and holds it until it is accepted. Afterwards the T bit
  // is flipped so that a late mode change would show up in the results.
  task automatic applyStimulus(input logic [31:0] w, input logic [31:0] pc, input logic ab, input logic t);
    bit done;
    done = 1'b0;
    @(negedge i_clk);
    i_word = w; i_word_pc = pc; i_iabort = ab; i_cpsr_t = t; i_word_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(posedge i_clk);
      if (o_word_ready) done = 1'b1;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: actual not_accepted required accepted pc=%h", pc);
    end
    @(negedge i_clk);
    i_word_valid = 1'b0;
    i_cpsr_t = ~t;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    i_reset_n = 1'b1;
    #1 checkOutput("ready_after_reset", {66'd0, o_word_ready}, 67'd1);

    // Thumb, aligned word: both halfwords.
    applyStimulus(32'hBEEF_CAFE, 32'h0000_0100, 1'b0, 1'b1);
    idleCycles(4);
    // Thumb, mid-word branch target: upper halfword only.
    applyStimulus(32'h1111_2222, 32'h0000_0202, 1'b0, 1'b1);
    idleCycles(3);
    // ARM word.
    applyStimulus(32'hE3A0_0001, 32'h0000_0300, 1'b0, 1'b0);
    idleCycles(3);
    // Stall in LO for three cycles, then resume.
    applyStimulus(32'hBEEF_CAFE, 32'h0000_0100, 1'b0, 1'b1);
    i_stall = 1'b1;
    idleCycles(3);
    i_stall = 1'b0;
    idleCycles(4);
    // Clear while stalled discards the buffered word.
    applyStimulus(32'hBEEF_CAFE, 32'h0000_0100, 1'b0, 1'b1);
    i_stall = 1'b1;
    idleCycles(1);
    i_clear = 1'b1;
    idleCycles(1);
    i_clear = 1'b0;
    idleCycles(1);
    i_stall = 1'b0;
    idleCycles(4);
    // Fetch abort.
    applyStimulus(32'h1234_5678, 32'h0000_0400, 1'b1, 1'b1);
    idleCycles(3);
    // Asynchronous reset while in HI: outputs drop at once, upper half lost.
    applyStimulus(32'hBEEF_CAFE, 32'h0000_0100, 1'b0, 1'b1);
    @(negedge i_clk);
    #2 i_reset_n = 1'b0;
    #1 checkOutput("async_reset", actualOut, 67'd0);
    idleCycles(2);
    i_reset_n = 1'b1;
    #1 checkOutput("ready_after_reset2", {66'd0, o_word_ready}, 67'd1);
    idleCycles(3);

    // Randomised traffic.
    for (int n = 0; n < 600; n++) begin
      @(negedge i_clk);
      i_word_valid = 1'($urandom_range(0, 1));
      i_word       = $urandom;
      i_word_pc    = $urandom;
      i_iabort     = ($urandom_range(0, 9) == 0);
      i_cpsr_t     = 1'($urandom_range(0, 1));
      i_stall      = ($urandom_range(0, 3) == 0);
      i_clear      = ($urandom_range(0, 19) == 0);
    end
    @(negedge i_clk);
    i_word_valid = 1'b0; i_stall = 1'b0; i_clear = 1'b0;
    idleCycles(5);

`ifdef ZAP_HWSEQ_PERF_CNT_EN
    checkOutput("hw_count", {35'd0, o_hw_count}, {35'd0, expectedHw[31:0]});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/zap_thumb_hword_sequencer.md
ZAP_THUMB_HWORD_SEQUENCER -- requirements
Module: zap_thumb_hword_sequencer

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: i_reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: i_clear  in  1  pipeline flush (OR of writeback/ALU/decode clears).
REQ-004 SHALL have: i_stall  in  1  downstream stall (OR of data/shifter/issue/decode stalls).
REQ-005 SHALL have: i_word  in  32  I-cache fetch word; i_word_valid  in  1  qualifier; i_word_pc  in  32  fetch PC; i_iabort  in  1  fetch abort; i_cpsr_t  in  1  Thumb state.
REQ-006 SHALL have: o_word_ready  out  1  word accepted when i_word_valid && o_word_ready.
REQ-007 SHALL have: o_instruction  out  32  issued instruction, Thumb halfword zero-extended in [15:0]; o_instruction_valid  out  1; o_pc  out  32  issued instruction PC; o_iabort  out  1; o_thumb  out  1  issued instruction is 16-bit.

Function
REQ-008 SHALL hold one buffer (word, PC, abort, T) and a state in {EMPTY, LO, HI, ARM, ABT}.
REQ-009 SHALL drive o_word_ready = !i_clear && (state==EMPTY || (state in {HI, ARM, ABT} && !i_stall)), combinationally.
REQ-010 On accept SHALL load the buffer; next state ABT if i_iabort, else ARM if !i_cpsr_t, else LO if i_word_pc[1]==0, else HI.
REQ-011 When !i_stall and state LO SHALL register o_instruction={16'd0,word[15:0]}, o_pc={pc[31:2],2'b00}, valid=1, o_thumb=1; next HI.
REQ-012 When !i_stall and state HI SHALL register {16'd0,word[31:16]}, o_pc={pc[31:2],2'b10}, valid=1, o_thumb=1; next EMPTY unless a same-cycle accept (REQ-010).
REQ-013 When !i_stall and state ARM SHALL register word, o_pc=pc, valid=1, o_thumb=0; ABT SHALL register o_instruction=0, o_iabort=1, valid=1; both then EMPTY or newly accepted state.
REQ-014 When !i_stall and state EMPTY SHALL register o_instruction_valid=0, o_iabort=0.
REQ-015 Latency: word accepted at edge N SHALL issue its first output at edge N+1 (absent stall); one output per unstalled cycle thereafter.
REQ-016 i_stall SHALL freeze all outputs and non-EMPTY state; an EMPTY buffer SHALL still accept during stall.
REQ-017 i_clear SHALL take priority over stall and accept: next edge valid=0, o_iabort=0, state EMPTY, input word discarded.
REQ-018 T bit SHALL be sampled only at accept; later i_cpsr_t changes SHALL not affect a buffered word.

Reset
REQ-019 i_reset_n low SHALL immediately force state EMPTY and all outputs/buffer/counter to 0; o_word_ready SHALL be 1 after release when i_clear is low.
REQ-020 Reset mid-operation SHALL discard any pending halfword with no output.

Configuration
REQ-021 With ZAP_HWSEQ_PERF_CNT_EN defined SHALL add output o_hw_count (out, 32) incrementing by 1 per issued Thumb halfword, wrapping 0xFFFFFFFF->0, unaffected by i_clear; without it the port and counter SHALL not exist.

Structure
REQ-022 State enum and halfword width constant SHALL live in package zap_hwseq_pkg.
REQ-023 SHALL be a single module; no sub-module.

Verification
REQ-024 Thumb, pc=0x100, word=0xBEEF_CAFE, no stall -> issues 0x0000CAFE@0x100, then 0x0000BEEF@0x102, o_thumb=1.
REQ-025 Thumb, pc=0x202 (mid-word branch target), word=0x1111_2222 -> single issue 0x00001111@0x202.
REQ-026 ARM, pc=0x300, word=0xE3A0_0001 -> one issue 0xE3A00001@0x300, o_thumb=0.
REQ-027 State LO, i_stall high 3 cycles -> outputs frozen, then 0x0000CAFE, 0x0000BEEF resume in order; i_clear during stall -> valid=0 next edge, nothing further issued.
REQ-028 i_iabort with pc=0x400 -> one issue valid=1, o_iabort=1, o_instruction=0; i_reset_n pulsed low in state HI -> outputs 0 immediately, no upper halfword issued.
